// File: rtl/branch_decider_pkg.sv
// ============================================================================
// Module   : branch_decider_pkg
// Brief    : Branch condition encodings shared by the branch decider files.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_decider_pkg;

    typedef logic [2:0] br_type_t;

    localparam br_type_t BR_Z      = 3'd0;
    localparam br_type_t BR_C      = 3'd1;
    localparam br_type_t BR_S      = 3'd2;
    localparam br_type_t BR_V      = 3'd3;
    localparam br_type_t BR_NZ     = 3'd4;
    localparam br_type_t BR_NC     = 3'd5;
    localparam br_type_t BR_NS     = 3'd6;
    localparam br_type_t BR_ALWAYS = 3'd7;

endpackage : branch_decider_pkg

`default_nettype wire

// File: rtl/branch_decider_cond_eval.sv
// ============================================================================
// Module   : br_cond_eval
// Brief    : Combinational branch condition mux over the ALU flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_cond_eval
    import branch_decider_pkg::*;
(
    input  logic     zFlag,
    input  logic     carryFlag,
    input  logic     signFlag,
    input  logic     overflowFlag,
    input  br_type_t brType,
    output logic     cond
);

    always_comb begin
        cond = 1'b0;
        case (brType)
            BR_Z:      cond = zFlag;
            BR_C:      cond = carryFlag;
            BR_S:      cond = signFlag;
            BR_V:      cond = overflowFlag;
            BR_NZ:     cond = !zFlag;
            BR_NC:     cond = !carryFlag;
            BR_NS:     cond = !signFlag;
            BR_ALWAYS: cond = 1'b1;
            default:   cond = 1'b0;
        endcase
    end

endmodule : br_cond_eval

`default_nettype wire

// File: rtl/branch_decider.sv
// ============================================================================
// Module   : branch_decider
// Brief    : Registered branch decision with one-cycle valid strobe. Defining
//            BRANCH_DECIDER_TAKEN_CNT_EN adds a saturating taken counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_decider
    import branch_decider_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             zFlag,
    input  logic             carryFlag,
    input  logic             signFlag,
    input  logic             overflowFlag,
    input  logic [2:0]       brType,
    input  logic             brValid,
    output logic             brTrue,
    output logic             brTrueValid
`ifdef BRANCH_DECIDER_TAKEN_CNT_EN
    ,
    output logic [CNT_W-1:0] takenCount
`endif
);

    logic cond;
    logic br_true_d, br_true_q;
    logic br_valid_d, br_valid_q;

    br_cond_eval u_cond_eval (
        .zFlag        (zFlag),
        .carryFlag    (carryFlag),
        .signFlag     (signFlag),
        .overflowFlag (overflowFlag),
        .brType       (br_type_t'(brType)),
        .cond         (cond)
    );

    // Hold the last decision while idle so X on idle inputs never reaches brTrue.
    always_comb begin
        br_true_d  = br_true_q;
        br_valid_d = 1'b0;
        if (brValid) begin
            br_true_d  = cond;
            br_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_true_q  <= 1'b0;
            br_valid_q <= 1'b0;
        end else begin
            br_true_q  <= br_true_d;
            br_valid_q <= br_valid_d;
        end
    end

    assign brTrue      = br_true_q;
    assign brTrueValid = br_valid_q;

`ifdef BRANCH_DECIDER_TAKEN_CNT_EN
    logic [CNT_W-1:0] taken_cnt_d, taken_cnt_q;

    always_comb begin
        taken_cnt_d = taken_cnt_q;
        if (brValid && cond && (taken_cnt_q != {CNT_W{1'b1}})) begin
            taken_cnt_d = taken_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_cnt_q <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign takenCount = taken_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule : branch_decider

`default_nettype wire

// File: tb/tb_branch_decider.sv
// ============================================================================
// Module   : tb_branch_decider
// Brief    : Directed self-checking bench for branch_decider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_decider;

    localparam int CNT_W = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       zFlag, carryFlag, signFlag, overflowFlag;
    logic [2:0] brType;
    logic       brValid;
    logic       brTrue, brTrueValid;
`ifdef BRANCH_DECIDER_TAKEN_CNT_EN
    logic [CNT_W-1:0] takenCount;
`endif

    int vectors = 0;
    int errs    = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    branch_decider #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .zFlag        (zFlag),
        .carryFlag    (carryFlag),
        .signFlag     (signFlag),
        .overflowFlag (overflowFlag),
        .brType       (brType),
        .brValid      (brValid),
        .brTrue       (brTrue),
        .brTrueValid  (brTrueValid)
`ifdef BRANCH_DECIDER_TAKEN_CNT_EN
        ,
        .takenCount   (takenCount)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus, then check outputs 1 time unit after the edge.
    task automatic step(input string tag, input logic rst_v, input logic v, input logic [2:0] t,
                        input logic z, input logic c, input logic s, input logic o,
                        input logic exp_true, input logic exp_valid);
        rst_n = rst_v; brValid = v; brType = t;
        zFlag = z; carryFlag = c; signFlag = s; overflowFlag = o;
        @(posedge clk);
        #1;
        if (!rst_v) exp_cnt = 0;
        else if (v && exp_true && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        check({tag, ".brTrue"}, {31'd0, brTrue}, {31'd0, exp_true});
        check({tag, ".brTrueValid"}, {31'd0, brTrueValid}, {31'd0, exp_valid});
`ifdef BRANCH_DECIDER_TAKEN_CNT_EN
        check({tag, ".takenCount"}, {28'd0, takenCount}, exp_cnt);
`endif
    endtask

    initial begin
        rst_n = 1'b0; brValid = 1'b0; brType = 3'd0;
        zFlag = 1'b0; carryFlag = 1'b0; signFlag = 1'b0; overflowFlag = 1'b0;
        @(posedge clk); #1;

        // Request coincident with reset is discarded
        step("rst_req", 1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        //            tag       rst  vld  type  z     c     s     o     brT   vld
        step("bz_t",    1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("bc_f",    1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("bs_t",    1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step("bv_f",    1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step("bnz_t",   1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step("br_t",    1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("bz_f",    1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step("bc_t",    1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step("bs_f",    1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step("bv_t",    1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("bnz_f",   1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("bnc_t",   1'b1, 1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step("bnc_f",   1'b1, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("bns_t",   1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step("bns_f",   1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("br_t2",   1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Idle cycles with toggling / unknown inputs: brTrue holds 1
        step("idle0",   1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("idle1",   1'b1, 1'b0, 3'd4, 1'b1, 1'bx, 1'b1, 1'bx, 1'b1, 1'b0);
        step("idle2",   1'b1, 1'b0, 3'bxxx, 1'bx, 1'bx, 1'bx, 1'bx, 1'b1, 1'b0);
        // Then a not-taken decision, and idle must hold 0
        step("bz_f2",   1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("idle3",   1'b1, 1'b0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Mid-stream reset with a request pending
        step("pre_rst", 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("mid_rst", 1'b0, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("post_rst",1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Saturation run: 20 consecutive always-taken requests from a fresh reset
        step("sat_rst", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step("sat", 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        step("sat_hold",1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef BRANCH_DECIDER_TAKEN_CNT_EN
        check("sat_final", {28'd0, takenCount}, 32'd15);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule : tb_branch_decider

`default_nettype wire

// File: doc/branch_decider.md
BRANCH_DECIDER -- requirements
Module: branch_decider

Interface
REQ-001 Parameter CNT_W, default 16: width of the taken-branch counter (used only when the Configuration feature is enabled).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 zFlag  input  1  zero flag.
REQ-005 carryFlag  input  1  carry flag.
REQ-006 signFlag  input  1  sign (negative) flag.
REQ-007 overflowFlag  input  1  overflow flag.
REQ-008 brType  input  3  branch condition select.
REQ-009 brValid  input  1  request qualifier; flags and brType are sampled only when high.
REQ-010 brTrue  output  1  registered decision: 1 = branch taken.
REQ-011 brTrueValid  output  1  high for exactly one cycle when brTrue carries a new decision.
REQ-012 takenCount  output  CNT_W  saturating count of taken decisions; exists only with BRANCH_DECIDER_TAKEN_CNT_EN.

Function
REQ-013 Condition encoding for brType:
- 0 BZ: zFlag
- 1 BC: carryFlag
- 2 BS: signFlag
- 3 BV: overflowFlag
- 4 BNZ: !zFlag
- 5 BNC: !carryFlag
- 6 BNS: !signFlag
- 7 BR: always 1
REQ-014 Latency is 1 cycle: on a rising edge with brValid=1, brTrue <= condition(brType, flags) and brTrueValid <= 1.
REQ-015 On a rising edge with brValid=0: brTrue holds its previous value and brTrueValid <= 0.
REQ-016 Back-to-back requests (brValid high on consecutive cycles) each produce a decision; throughput is 1 per cycle, with no stall and no backpressure.
REQ-017 Flags and brType are don't-care while brValid=0; X on them while brValid=0 does not propagate to outputs.
REQ-018 Decision depends only on the current-cycle inputs; no flag history is kept.

Reset
REQ-019 While rst_n=0 at a rising edge: brTrue <= 0, brTrueValid <= 0, takenCount <= 0, regardless of brValid.
REQ-020 A request coincident with the reset edge is discarded; the first decision after release requires brValid=1 on a cycle with rst_n=1.

Configuration
REQ-021 Macro BRANCH_DECIDER_TAKEN_CNT_EN, when defined: takenCount port exists and increments by 1 on each edge where brValid=1 and the evaluated condition is 1; it saturates at all-ones (2^CNT_W - 1) and does not wrap.
REQ-022 When BRANCH_DECIDER_TAKEN_CNT_EN is not defined: no takenCount port and no counter logic; all other behaviour is identical.

Structure
REQ-023 A shared package holds the brType encoding constants (BR_Z=0, BR_C=1, BR_S=2, BR_V=3, BR_NZ=4, BR_NC=5, BR_NS=6, BR_ALWAYS=7) and a 3-bit br_type_t typedef.
REQ-024 One combinational sub-module, br_cond_eval (inputs: flags and brType; output: cond), holds the condition mux; branch_decider holds the registers, the handshake and the optional counter.

Verification
REQ-025 zFlag=1, brType=0, brValid=1 -> next cycle brTrue=1, brTrueValid=1.
REQ-026 carryFlag=0, brType=1, brValid=1 -> brTrue=0; then signFlag=1, brType=2 on the following cycle -> brTrue=1 (back-to-back, brTrueValid stays high both cycles).
REQ-027 overflowFlag=0, brType=3 -> brTrue=0; zFlag=0, brType=4 -> brTrue=1; brType=7 with all flags 0 -> brTrue=1.
REQ-028 brValid=0 with brType/flags toggling for 3 cycles -> brTrue unchanged, brTrueValid=0 throughout.
REQ-029 rst_n=0 asserted mid-stream with brValid=1 -> next edge brTrue=0, brTrueValid=0, takenCount=0; after release the first request is evaluated normally.
REQ-030 With BRANCH_DECIDER_TAKEN_CNT_EN and CNT_W=4: 20 consecutive taken requests (brType=7) -> takenCount reaches 15 and holds at 15.
